// File: rtl/vga_frame_capture_if.sv
// VGA pixel input and capture-memory write port.
// master drives sync/colour and receives writes; slave is the capturer.
interface vga_frame_capture_if #(
  parameter int ADDR_W = 19
);
  logic              Hsync;
  logic              Vsync;
  logic [7:0]        R;
  logic [7:0]        G;
  logic [7:0]        B;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;

  modport master (
    output Hsync, Vsync, R, G, B,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  Hsync, Vsync, R, G, B,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_frame_capture.sv
// Captures one VGA frame window into a linear pixel memory.
// Define CAPTURE_GRAY_EN to store {Y,Y,Y} luma instead of raw {R,G,B}.
module vga_frame_capture #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int CAP_W    = 640,
  parameter int CAP_H    = 480,
  parameter int ADDR_W   = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  vga_frame_capture_if.slave   vif,
  output logic                 busy,
  output logic                 DONE,
  output logic                 err
);

  localparam int CW = (CAP_W < H_ACTIVE) ? CAP_W : H_ACTIVE;
  localparam int CH = (CAP_H < V_ACTIVE) ? CAP_H : V_ACTIVE;
  localparam logic [11:0] X_LO = 12'(H_SYNC + H_BP);
  localparam logic [11:0] X_HI = 12'(H_SYNC + H_BP + CW);
  localparam logic [10:0] Y_LO = 11'(V_SYNC + V_BP);
  localparam logic [10:0] Y_HI = 11'(V_SYNC + V_BP + CH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CW * CH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } state_t;

  state_t state, state_n;

  logic       hs1, vs1, hs2, vs2;
  logic [7:0] r1, g1, b1;
  logic       hfall, vfall;

  logic [10:0] h_cnt, h_pos;
  logic [9:0]  v_cnt, v_pos;
  logic        in_win;

  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       wdata_q;
  logic [23:0]       pix;
  logic              we_q;

  logic do_wr, set_done, set_err, arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      hs2 <= 1'b1;
      vs2 <= 1'b1;
      r1  <= '0;
      g1  <= '0;
      b1  <= '0;
    end else begin
      hs1 <= vif.Hsync;
      vs1 <= vif.Vsync;
      hs2 <= hs1;
      vs2 <= vs1;
      r1  <= vif.R;
      g1  <= vif.G;
      b1  <= vif.B;
    end
  end

  assign hfall = hs2 & ~hs1;
  assign vfall = vs2 & ~vs1;

  // Positions belong to the stage-1 sample; the falling-edge sample is 0.
  always_comb begin
    h_pos = hfall ? '0 : h_cnt;
    v_pos = v_cnt;
    if (vfall)
      v_pos = '0;
    else if (hfall && v_cnt != 10'h3ff)
      v_pos = v_cnt + 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= (&h_pos) ? h_pos : h_pos + 11'd1;
      v_cnt <= v_pos;
    end
  end

  assign in_win = ({1'b0, h_pos} >= X_LO) &&
                  ({1'b0, h_pos} <  X_HI) &&
                  ({1'b0, v_pos} >= Y_LO) &&
                  ({1'b0, v_pos} <  Y_HI);

`ifdef CAPTURE_GRAY_EN
  logic [7:0] luma;
  assign luma = 8'(({2'b0, r1} + {1'b0, g1, 1'b0} + {2'b0, b1}) >> 2);
  assign pix  = {luma, luma, luma};
`else
  assign pix = {r1, g1, b1};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_wr    = 1'b0;
    set_done = 1'b0;
    set_err  = 1'b0;
    arm      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = ARMED;
          arm     = 1'b1;
        end
      end
      ARMED: begin
        if (vfall)
          state_n = CAPTURE;
      end
      CAPTURE: begin
        if (vfall) begin
          set_err = 1'b1;
          state_n = IDLE;
        end else if (in_win) begin
          do_wr = 1'b1;
          if (wcnt == LAST) begin
            set_done = 1'b1;
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wcnt    <= '0;
      DONE    <= 1'b0;
      err     <= 1'b0;
    end else begin
      we_q <= do_wr;
      if (do_wr) begin
        addr_q  <= wcnt;
        wdata_q <= pix;
        wcnt    <= wcnt + 1'b1;
      end
      if (arm)
        wcnt <= '0;
      if (arm)
        DONE <= 1'b0;
      else if (set_done)
        DONE <= 1'b1;
      if (arm)
        err <= 1'b0;
      else if (set_err)
        err <= 1'b1;
    end
  end

  assign vif.mem_we    = we_q;
  assign vif.mem_addr  = addr_q;
  assign vif.mem_wdata = wdata_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a reduced 8x4 timing.
// Two instances: full 8x4 window and a 4x2 corner window.
module tb_vga_frame_capture;

  localparam int HS  = 2;
  localparam int HBP = 2;
  localparam int HA  = 8;
  localparam int HT  = 14;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int VA  = 4;
  localparam int VT  = 7;

`ifdef CAPTURE_GRAY_EN
  localparam logic [23:0] C_PIX = 24'h505050;
`else
  localparam logic [23:0] C_PIX = 24'h285078;
`endif

  typedef struct packed {
    logic [5:0]  a;
    logic [23:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       hs = 1'b1;
  logic       vs = 1'b1;
  logic [7:0] r = '0;
  logic [7:0] g = '0;
  logic [7:0] b = '0;
  logic       busy_a, done_a, err_a;
  logic       busy_b, done_b, err_b;
  logic       exp_a = 1'b0;
  logic       exp_b = 1'b0;

  int total = 0;
  int bad   = 0;
  int we_a  = 0;
  int we_b  = 0;
  int wa0;

  ent_t qa[$];
  ent_t qb[$];

  always #5 clk = ~clk;

  vga_frame_capture_if #(.ADDR_W(6)) bus_a ();
  vga_frame_capture_if #(.ADDR_W(6)) bus_b ();

  assign bus_a.Hsync = hs;
  assign bus_a.Vsync = vs;
  assign bus_a.R     = r;
  assign bus_a.G     = g;
  assign bus_a.B     = b;
  assign bus_b.Hsync = hs;
  assign bus_b.Vsync = vs;
  assign bus_b.R     = r;
  assign bus_b.G     = g;
  assign bus_b.B     = b;

  vga_frame_capture #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA),
    .CAP_W(8), .CAP_H(4), .ADDR_W(6)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vif(bus_a),
    .busy(busy_a), .DONE(done_a), .err(err_a)
  );

  vga_frame_capture #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA),
    .CAP_W(4), .CAP_H(2), .ADDR_W(6)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vif(bus_b),
    .busy(busy_b), .DONE(done_b), .err(err_b)
  );

  function automatic logic [23:0] exp_pix(input logic [7:0] pr,
                                          input logic [7:0] pg,
                                          input logic [7:0] pb);
`ifdef CAPTURE_GRAY_EN
    logic [9:0] s;
    s = {2'b0, pr} + {1'b0, pg, 1'b0} + {2'b0, pb};
    return {s[9:2], s[9:2], s[9:2]};
`else
    return {pr, pg, pb};
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic monitor();
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus_a.mem_we) begin
        we_a++;
        if (qa.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_unexpected_write actual=addr %0d required=none",
                   bus_a.mem_addr);
        end else begin
          e = qa.pop_front();
          chk("a_addr", 32'(bus_a.mem_addr), 32'(e.a));
          chk("a_data", 32'(bus_a.mem_wdata), 32'(e.d));
          chk("a_done_at_write", 32'(done_a), 32'(e.a == 6'd31));
        end
      end
      if (rst_n && bus_b.mem_we) begin
        we_b++;
        if (qb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_unexpected_write actual=addr %0d required=none",
                   bus_b.mem_addr);
        end else begin
          e = qb.pop_front();
          chk("b_addr", 32'(bus_b.mem_addr), 32'(e.a));
          chk("b_data", 32'(bus_b.mem_wdata), 32'(e.d));
          chk("b_done_at_write", 32'(done_b), 32'(e.a == 6'd7));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      hs = 1'b1;
      vs = 1'b1;
      r = '0;
      g = '0;
      b = '0;
      start_a = 1'b0;
      start_b = 1'b0;
    end
  endtask

  task automatic pulse_start(input logic sa, input logic sb);
    @(posedge clk);
    #1;
    start_a = sa;
    start_b = sb;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // mode 0: pixel {x,y,A5}; mode 1: constant R=40 G=80 B=120
  task automatic run_frame(input int mode, input int start_line,
                           input int rst_line, input int abort_at);
    int n;
    logic [7:0] px, py;
    n = 0;
    for (int l = 0; l < VT; l++) begin
      for (int c = 0; c < HT; c++) begin
        @(posedge clk);
        #1;
        start_a = (l == start_line && c == 0);
        if (l == rst_line && c == 0) begin
          rst_n = 1'b0;
          #1;
          chk("rst_mem_we", 32'(bus_a.mem_we), 0);
          chk("rst_mem_addr", 32'(bus_a.mem_addr), 0);
          chk("rst_mem_wdata", 32'(bus_a.mem_wdata), 0);
          chk("rst_busy", 32'(busy_a), 0);
          chk("rst_done", 32'(done_a), 0);
          chk("rst_err", 32'(err_a), 0);
          exp_a = 1'b0;
          exp_b = 1'b0;
        end
        if (l == rst_line && c == 2)
          rst_n = 1'b1;
        if (abort_at >= 0 && n == abort_at) begin
          vs = 1'b0;
          hs = 1'b1;
          r = '0;
          g = '0;
          b = '0;
          repeat (HT) @(posedge clk);
          #1;
          vs = 1'b1;
          return;
        end
        hs = (c < HS) ? 1'b0 : 1'b1;
        vs = (l < VS) ? 1'b0 : 1'b1;
        r = '0;
        g = '0;
        b = '0;
        if (c >= HS + HBP && c < HS + HBP + HA &&
            l >= VS + VBP && l < VS + VBP + VA) begin
          px = 8'(c - HS - HBP);
          py = 8'(l - VS - VBP);
          if (mode == 0) begin
            r = px;
            g = py;
            b = 8'hA5;
          end else begin
            r = 8'd40;
            g = 8'd80;
            b = 8'd120;
          end
          n++;
          if (exp_a)
            qa.push_back({6'(py * 8 + px),
                          (mode == 0) ? exp_pix(r, g, b) : C_PIX});
          if (exp_b && px < 8'd4 && py < 8'd2)
            qb.push_back({6'(py * 4 + px),
                          (mode == 0) ? exp_pix(r, g, b) : C_PIX});
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst_n = 1'b0;
    idle(3);
    chk("reset_mem_we", 32'(bus_a.mem_we), 0);
    chk("reset_mem_addr", 32'(bus_a.mem_addr), 0);
    chk("reset_mem_wdata", 32'(bus_a.mem_wdata), 0);
    chk("reset_busy", 32'(busy_a), 0);
    chk("reset_done", 32'(done_a), 0);
    chk("reset_err", 32'(err_a), 0);
    rst_n = 1'b1;
    idle(4);

    // full 8x4 window and 4x2 corner window from the same frame
    pulse_start(1'b1, 1'b1);
    chk("armed_busy_a", 32'(busy_a), 1);
    chk("armed_busy_b", 32'(busy_b), 1);
    idle(3);
    exp_a = 1'b1;
    exp_b = 1'b1;
    run_frame(0, -1, -1, -1);
    exp_a = 1'b0;
    exp_b = 1'b0;
    idle(20);
    chk("full_done", 32'(done_a), 1);
    chk("full_err", 32'(err_a), 0);
    chk("full_busy", 32'(busy_a), 0);
    chk("full_writes", 32'(we_a), 32);
    chk("full_queue_left", 32'(qa.size()), 0);
    chk("win_done", 32'(done_b), 1);
    chk("win_writes", 32'(we_b), 8);
    chk("win_queue_left", 32'(qb.size()), 0);

    // early Vsync after 10 writes
    wa0 = we_a;
    pulse_start(1'b1, 1'b0);
    idle(3);
    exp_a = 1'b1;
    run_frame(0, -1, -1, 10);
    exp_a = 1'b0;
    idle(20);
    chk("abort_err", 32'(err_a), 1);
    chk("abort_done", 32'(done_a), 0);
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_writes", 32'(we_a - wa0), 10);
    chk("abort_queue_left", 32'(qa.size()), 0);

    // no start for two frames, then start mid-frame
    wa0 = we_a;
    run_frame(0, -1, -1, -1);
    run_frame(0, -1, -1, -1);
    chk("nostart_writes", 32'(we_a - wa0), 0);
    chk("nostart_busy", 32'(busy_a), 0);
    run_frame(0, 3, -1, -1);
    chk("midstart_busy", 32'(busy_a), 1);
    chk("midstart_no_writes", 32'(we_a - wa0), 0);
    exp_a = 1'b1;
    run_frame(0, -1, -1, -1);
    exp_a = 1'b0;
    idle(20);
    chk("midstart_done", 32'(done_a), 1);
    chk("midstart_err_cleared", 32'(err_a), 0);
    chk("midstart_writes", 32'(we_a - wa0), 32);
    chk("midstart_queue_left", 32'(qa.size()), 0);

    // reset during capture, then a clean frame
    pulse_start(1'b1, 1'b0);
    idle(3);
    exp_a = 1'b1;
    run_frame(0, -1, 3, -1);
    exp_a = 1'b0;
    idle(20);
    chk("rstcap_queue_left", 32'(qa.size()), 0);
    chk("rstcap_busy", 32'(busy_a), 0);
    chk("rstcap_err", 32'(err_a), 0);
    wa0 = we_a;
    pulse_start(1'b1, 1'b0);
    idle(3);
    exp_a = 1'b1;
    run_frame(0, -1, -1, -1);
    exp_a = 1'b0;
    idle(20);
    chk("clean_done", 32'(done_a), 1);
    chk("clean_writes", 32'(we_a - wa0), 32);
    chk("clean_queue_left", 32'(qa.size()), 0);

    // constant colour frame checks the stored pixel format
    pulse_start(1'b1, 1'b0);
    idle(3);
    exp_a = 1'b1;
    run_frame(1, -1, -1, -1);
    exp_a = 1'b0;
    idle(20);
    chk("colour_done", 32'(done_a), 1);
    chk("colour_last_data", 32'(bus_a.mem_wdata), 32'(C_PIX));
    chk("colour_queue_left", 32'(qa.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
